oc8051_cxfetch: RTL and testbench
=================================

OC8051_CXFETCH -- requirements
Module: oc8051_cxfetch

Interface
REQ-001 The block SHALL have parameter BUF_DEPTH, default 8: byte buffer depth, power of two, at least 8.
REQ-002 The block SHALL have input clk, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have input rst, 1 bit: reset, synchronous and active-low.
REQ-004 The block SHALL have input redirect, 1 bit: load a new fetch address and flush the buffer.
REQ-005 The block SHALL have input redirect_addr, 16 bits: code address loaded on redirect.
REQ-006 The block SHALL have input fetch_en, 1 bit: when low, no new ROM words are captured.
REQ-007 The block SHALL have output cxrom_addr, 16 bits: word address driven to the combinational code ROM.
REQ-008 The block SHALL have input cxrom_data_in, 32 bits: ROM word, valid in the same cycle as cxrom_addr.
REQ-009 The block SHALL have output byte_out, 8 bits: oldest buffered code byte.
REQ-010 The block SHALL have output byte_pc, 16 bits: code address of byte_out.
REQ-011 The block SHALL have output byte_valid, 1 bit: byte_out and byte_pc are valid.
REQ-012 The block SHALL have input byte_ready, 1 bit: the consumer accepts byte_out.
REQ-013 The block SHALL have output fetch_cnt, 16 bits: count of captured ROM words (see REQ-030).

Function
REQ-014 The block SHALL have two states: IDLE and FETCH.
- IDLE to FETCH on redirect.
- FETCH to FETCH on redirect.
- No other transitions except reset.
REQ-015 The block SHALL drive cxrom_addr from the fetch_pc register at all times.
REQ-016 The block SHALL treat cxrom_data_in[8k+7:8k] as the byte at address fetch_pc+k (k=0..3), with all address sums modulo 2^16.
REQ-017 The block SHALL define push = (state==FETCH) & fetch_en & ~redirect & (count <= BUF_DEPTH-4), with count sampled before any pop in that cycle.
REQ-018 On push, the block SHALL append the 4 bytes, with their addresses, in ascending order and SHALL set fetch_pc to fetch_pc+4 (0xFFFC+4 wraps to 0x0000).
REQ-019 The block SHALL define pop = byte_valid & byte_ready & ~redirect; on pop it SHALL remove the oldest byte.
REQ-020 The block SHALL update count as count + 4*push - pop; push and pop in the same cycle are both honoured.
REQ-021 The block SHALL drive byte_valid = (count != 0) combinationally from registered state.
REQ-022 While byte_valid is high and byte_ready is low, byte_out and byte_pc SHALL remain stable.
REQ-023 Redirect SHALL have priority over push and pop.
- It sets count to 0 and fetch_pc to redirect_addr.
- It sets state to FETCH.
- Any handshake in the same cycle is discarded.
REQ-024 Latency: redirect at cycle N SHALL yield cxrom_addr=redirect_addr in N+1, a push in N+1 (if fetch_en), and byte_valid=1 in N+2.
REQ-025 Unaligned redirect_addr SHALL be supported; 0xFFFE yields bytes at 0xFFFE, 0xFFFF, 0x0000, 0x0001.
REQ-026 The block SHALL never overflow: count never exceeds BUF_DEPTH. It SHALL never underflow: no pop when count is 0.

Reset
REQ-027 While rst is low at a clock edge, the block SHALL set: state IDLE, fetch_pc 0x0000, count 0, read/write pointers 0, fetch_cnt 0.
REQ-028 Consequently after reset: cxrom_addr=0x0000, byte_valid=0; byte_out and byte_pc are don't-care while byte_valid=0.
REQ-029 Reset asserted mid-operation SHALL discard all buffered bytes, and no push occurs in that cycle.

Configuration
REQ-030 Macro OC8051_CXFETCH_STATS_EN SHALL control the fetch counter.
- Defined: fetch_cnt increments by 1 on every push, saturates at 0xFFFF, and is cleared only by reset (not by redirect).
- Undefined: fetch_cnt is tied to 0 and no counter logic exists.

Verification
REQ-031 Redirect to 0x0100 with ROM word at 0x0100 = 0x44332211 and byte_ready held 1 -> byte_out 0x11, 0x22, 0x33, 0x44 with byte_pc 0x0100..0x0103 on consecutive cycles, first byte_valid 2 cycles after redirect.
REQ-032 byte_ready held 0 after redirect, BUF_DEPTH=8 -> exactly two pushes (cxrom_addr advances to 0x0108 and stops), count=8, byte_out stable at the 0x0100 byte.
REQ-033 Redirect to 0xFFFE with byte_ready=1 -> byte_pc sequence 0xFFFE, 0xFFFF, 0x0000, 0x0001, and cxrom_addr wraps 0xFFFE -> 0x0002.
REQ-034 Redirect to 0x0200 asserted in the same cycle as a valid handshake while 6 bytes are buffered -> handshake discarded, byte_valid=0 next cycle, next byte_pc=0x0200.
REQ-035 rst low for one cycle mid-stream with 5 bytes buffered -> next cycle byte_valid=0, cxrom_addr=0x0000, state IDLE; no pushes until a redirect.
REQ-036 With OC8051_CXFETCH_STATS_EN defined: 3 pushes then a redirect -> fetch_cnt=3, unchanged by the redirect. Without the macro, fetch_cnt=0 throughout.

Source files
------------

// File: rtl/oc8051_cxfetch.sv
// oc8051_cxfetch: code-byte prefetcher for the 8051 core.
// Reads 32-bit words from a combinational code ROM and delivers them to the
// decoder as a stream of bytes with their code addresses.
// Optional feature macro: OC8051_CXFETCH_STATS_EN enables the saturating count of
// captured ROM words on fetch_cnt. When it is not defined, fetch_cnt is tied to 0.

module oc8051_cxfetch #(
    parameter int unsigned BUF_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect,
    input  logic [15:0] redirect_addr,
    input  logic        fetch_en,
    output logic [15:0] cxrom_addr,
    input  logic [31:0] cxrom_data_in,
    output logic [7:0]  byte_out,
    output logic [15:0] byte_pc,
    output logic        byte_valid,
    input  logic        byte_ready,
    output logic [15:0] fetch_cnt
);

    localparam int unsigned PTR_W = $clog2(BUF_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    localparam logic StIdle  = 1'b0;
    localparam logic StFetch = 1'b1;

    // Registered state
    logic             r_state;
    logic [15:0]      r_fetch_pc;
    logic [CNT_W-1:0] r_count;
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [7:0]       r_buf [BUF_DEPTH];

    // Next-state values
    logic             w_state_nxt;
    logic [15:0]      w_fetch_pc_nxt;
    logic [CNT_W-1:0] w_count_nxt;
    logic [PTR_W-1:0] w_wptr_nxt;
    logic [PTR_W-1:0] w_rptr_nxt;

    logic             w_valid;
    logic             w_push;
    logic             w_pop;

    // Handshake decode; count is the pre-pop occupancy, so room for a full word
    // means at most BUF_DEPTH-4 bytes currently held.
    always_comb begin
        w_valid = (r_count != '0);
        w_push  = (r_state == StFetch) & fetch_en & ~redirect &
                  (r_count <= CNT_W'(BUF_DEPTH - 4));
        w_pop   = w_valid & byte_ready & ~redirect;
    end

    // Next-state logic; redirect flushes the buffer and wins over push and pop.
    always_comb begin
        w_state_nxt    = r_state;
        w_fetch_pc_nxt = r_fetch_pc;
        w_count_nxt    = r_count;
        w_wptr_nxt     = r_wptr;
        w_rptr_nxt     = r_rptr;
        if (redirect) begin
            w_state_nxt    = StFetch;
            w_fetch_pc_nxt = redirect_addr;
            w_count_nxt    = '0;
            w_wptr_nxt     = '0;
            w_rptr_nxt     = '0;
        end else begin
            if (w_push) begin
                w_fetch_pc_nxt = r_fetch_pc + 16'd4;
                w_wptr_nxt     = r_wptr + PTR_W'(4);
            end
            if (w_pop) begin
                w_rptr_nxt = r_rptr + PTR_W'(1);
            end
            w_count_nxt = r_count + (w_push ? CNT_W'(4) : CNT_W'(0))
                                  - (w_pop  ? CNT_W'(1) : CNT_W'(0));
        end
    end

    // Control state registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= StIdle;
            r_fetch_pc <= 16'h0000;
            r_count    <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_fetch_pc <= w_fetch_pc_nxt;
            r_count    <= w_count_nxt;
            r_wptr     <= w_wptr_nxt;
            r_rptr     <= w_rptr_nxt;
        end
    end

    // Byte storage: a push writes the word's bytes in ascending address order.
    // Contents need no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (rst && w_push) begin
            for (int k = 0; k < 4; k++) begin
                r_buf[r_wptr + PTR_W'(k)] <= cxrom_data_in[8*k +: 8];
            end
        end
    end

    // Buffered bytes are contiguous and end just below fetch_pc, so the
    // oldest byte's address is fetch_pc minus the occupancy.
    always_comb begin
        cxrom_addr = r_fetch_pc;
        byte_valid = w_valid;
        byte_out   = r_buf[r_rptr];
        byte_pc    = r_fetch_pc - 16'(r_count);
    end

`ifdef OC8051_CXFETCH_STATS_EN
    logic [15:0] r_fetch_cnt;

    // Saturating count of captured words; only reset clears it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_fetch_cnt <= 16'h0000;
        end else if (w_push && (r_fetch_cnt != 16'hFFFF)) begin
            r_fetch_cnt <= r_fetch_cnt + 16'd1;
        end
    end

    assign fetch_cnt = r_fetch_cnt;
`else
    assign fetch_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_oc8051_cxfetch.sv
// Bench for oc8051_cxfetch: directed stimulus, scoreboard of expected
// {byte_pc, byte_out} pairs popped by a monitor on each accepted byte.

module tb_oc8051_cxfetch;

    logic        clk;
    logic        rst;
    logic        redirect;
    logic [15:0] redirect_addr;
    logic        fetch_en;
    logic [15:0] cxrom_addr;
    logic [31:0] cxrom_data_in;
    logic [7:0]  byte_out;
    logic [15:0] byte_pc;
    logic        byte_valid;
    logic        byte_ready;
    logic [15:0] fetch_cnt;

    int checks = 0;
    int errors = 0;

    logic [23:0] exp_q [$];

    oc8051_cxfetch #(.BUF_DEPTH(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .redirect      (redirect),
        .redirect_addr (redirect_addr),
        .fetch_en      (fetch_en),
        .cxrom_addr    (cxrom_addr),
        .cxrom_data_in (cxrom_data_in),
        .byte_out      (byte_out),
        .byte_pc       (byte_pc),
        .byte_valid    (byte_valid),
        .byte_ready    (byte_ready),
        .fetch_cnt     (fetch_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM contents: 0x0100 word is 0x44332211, elsewhere a simple address hash
    function automatic logic [7:0] rom_byte(input logic [15:0] a);
        case (a)
            16'h0100: rom_byte = 8'h11;
            16'h0101: rom_byte = 8'h22;
            16'h0102: rom_byte = 8'h33;
            16'h0103: rom_byte = 8'h44;
            default:  rom_byte = a[7:0] ^ a[15:8] ^ 8'h5A;
        endcase
    endfunction

    always_comb begin
        cxrom_data_in = {rom_byte(cxrom_addr + 16'd3), rom_byte(cxrom_addr + 16'd2),
                         rom_byte(cxrom_addr + 16'd1), rom_byte(cxrom_addr)};
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted byte must match the head of the scoreboard
    always @(negedge clk) begin
        logic [23:0] e;
        if (rst && byte_valid && byte_ready && !redirect) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_byte: got pc 0x%0h byte 0x%0h expected none",
                         byte_pc, byte_out);
            end else begin
                e = exp_q.pop_front();
                chk("byte_pc", {16'h0, byte_pc}, {16'h0, e[23:8]});
                chk("byte_out", {24'h0, byte_out}, {24'h0, e[7:0]});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Redirect for one cycle and queue the n bytes expected from addr onward
    task automatic do_redirect(input logic [15:0] addr, input int n, input logic rdy);
        exp_q.delete();
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({addr + 16'(i), rom_byte(addr + 16'(i))});
        end
        redirect      = 1'b1;
        redirect_addr = addr;
        byte_ready    = rdy;
        tick();
        redirect = 1'b0;
    endtask

    // Wait for the scoreboard to drain, then stop accepting
    task automatic wait_empty(input string name, input int max_cycles);
        int n = 0;
        while (exp_q.size() != 0 && n < max_cycles) begin
            tick();
            n++;
        end
        byte_ready = 1'b0;
        chk(name, exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] exp_cnt;
        rst           = 1'b0;
        redirect      = 1'b0;
        redirect_addr = 16'h0;
        fetch_en      = 1'b1;
        byte_ready    = 1'b0;
        repeat (3) tick();
        chk("rst_valid", byte_valid, 0);
        chk("rst_addr", cxrom_addr, 16'h0000);
        chk("rst_cnt", fetch_cnt, 16'h0000);
        rst = 1'b1;
        repeat (3) tick();
        chk("idle_addr", cxrom_addr, 16'h0000);
        chk("idle_valid", byte_valid, 0);

        // Aligned stream with consumer always ready
        do_redirect(16'h0100, 4, 1'b1);
        chk("t1_addr_n1", cxrom_addr, 16'h0100);
        chk("t1_valid_n1", byte_valid, 0);
        tick();
        chk("t1_valid_n2", byte_valid, 1);
        chk("t1_pc_n2", byte_pc, 16'h0100);
        repeat (3) tick();
        chk("t1_one_left", exp_q.size(), 1);
        wait_empty("t1_drain", 2);

        // Consumer stalled: exactly two pushes fill the buffer
        do_redirect(16'h0100, 8, 1'b0);
        repeat (5) tick();
        chk("t2_addr", cxrom_addr, 16'h0108);
        chk("t2_valid", byte_valid, 1);
        chk("t2_byte", byte_out, 8'h11);
        chk("t2_pc", byte_pc, 16'h0100);
        repeat (3) tick();
        chk("t2_addr_held", cxrom_addr, 16'h0108);
        chk("t2_byte_held", byte_out, 8'h11);
        byte_ready = 1'b1;
        wait_empty("t2_drain", 20);

        // Fetch address wraps through 0xFFFF
        do_redirect(16'hFFFE, 4, 1'b1);
        chk("t3_addr0", cxrom_addr, 16'hFFFE);
        tick();
        chk("t3_addr1", cxrom_addr, 16'h0002);
        wait_empty("t3_drain", 10);

        // Redirect collides with a handshake while 6 bytes are buffered
        do_redirect(16'h0300, 2, 1'b0);
        repeat (4) tick();
        byte_ready = 1'b1;
        wait_empty("t4_pre", 5);
        chk("t4_six_pc", byte_pc, 16'h0302);
        chk("t4_six_addr", cxrom_addr, 16'h0308);
        do_redirect(16'h0200, 4, 1'b1);
        chk("t4_flush_valid", byte_valid, 0);
        wait_empty("t4_drain", 10);

        // Reset mid-stream with 5 bytes buffered
        do_redirect(16'h0400, 3, 1'b0);
        repeat (4) tick();
        byte_ready = 1'b1;
        wait_empty("t5_pre", 5);
        chk("t5_five_pc", byte_pc, 16'h0403);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("t5_valid", byte_valid, 0);
        chk("t5_addr", cxrom_addr, 16'h0000);
        repeat (4) tick();
        chk("t5_idle_addr", cxrom_addr, 16'h0000);
        chk("t5_idle_valid", byte_valid, 0);
        chk("t5_cnt", fetch_cnt, 16'h0000);

        // Fetch counter: three single pushes across redirects, then a redirect
        fetch_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            do_redirect(16'h0500 + 16'(16 * i), 0, 1'b0);
            chk("t6_hold_addr", cxrom_addr, 16'h0500 + 16'(16 * i));
            fetch_en = 1'b1;
            tick();
            fetch_en = 1'b0;
            chk("t6_push_addr", cxrom_addr, 16'h0504 + 16'(16 * i));
            tick();
            chk("t6_no_push", cxrom_addr, 16'h0504 + 16'(16 * i));
        end
`ifdef OC8051_CXFETCH_STATS_EN
        exp_cnt = 16'd3;
`else
        exp_cnt = 16'd0;
`endif
        chk("t6_cnt", fetch_cnt, exp_cnt);
        do_redirect(16'h0600, 0, 1'b0);
        chk("t6_cnt_redirect", fetch_cnt, exp_cnt);
        tick();
        chk("t6_fetch_en_low_valid", byte_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
